// File: rtl/dcache_mshr.sv
// rtl/dcache_mshr.sv - data-cache miss status holding registers; optional counters under DCACHE_MSHR_STATS_EN
`ifndef INDEX_BITS
`define INDEX_BITS 5
`endif
`ifndef TAG_BITS
`define TAG_BITS (64 - 3 - `INDEX_BITS)
`endif

package dcache_mshr_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

module dcache_mshr
    import dcache_mshr_pkg::*;
#(
    parameter int MSHR_DEPTH = 4,
    parameter int LD_ID_BITS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    miss_en,
    input  logic [63:0]             miss_addr,
    input  logic [LD_ID_BITS-1:0]   miss_ld_id,
    output logic                    miss_accept,
    output logic                    mshr_full,
    output BUS_COMMAND              proc2mem_command,
    output logic [63:0]             proc2mem_addr,
    input  logic [3:0]              mem2proc_response,
    input  logic [3:0]              mem2proc_tag,
    input  logic [63:0]             mem2proc_data,
    output logic                    wr1_missed_load_en,
    output logic [`INDEX_BITS-1:0]  wr1_missed_load_idx,
    output logic [`TAG_BITS-1:0]    wr1_missed_load_tag,
    output logic [63:0]             wr1_data_from_Mem,
    output logic                    fill_valid,
    output logic [LD_ID_BITS-1:0]   fill_ld_id
`ifdef DCACHE_MSHR_STATS_EN
    ,
    output logic [31:0]             stat_miss_count,
    output logic [31:0]             stat_full_stall_count
`endif
);

    localparam int IDX_W = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_WAIT_ISSUE = 2'd1,
        ST_WAIT_DATA  = 2'd2
    } entry_state_t;

    entry_state_t          r_state   [MSHR_DEPTH];
    logic [60:0]           r_addr    [MSHR_DEPTH];
    logic [LD_ID_BITS-1:0] r_ld_id   [MSHR_DEPTH];
    logic [3:0]            r_mem_tag [MSHR_DEPTH];

    logic                    r_fill_valid;
    logic [`INDEX_BITS-1:0]  r_fill_idx;
    logic [`TAG_BITS-1:0]    r_fill_tag;
    logic [63:0]             r_fill_data;
    logic [LD_ID_BITS-1:0]   r_fill_ld_id;

    logic             w_free_found;
    logic [IDX_W-1:0] w_free_idx;
    logic             w_issue_found;
    logic [IDX_W-1:0] w_issue_idx;
    logic             w_fill_found;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_resp_accept;
    logic [60:0]      w_fill_addr;
    logic             w_unused_addr_lsbs;

    // the byte offset within a block never reaches the entry
    assign w_unused_addr_lsbs = ^miss_addr[2:0];

    // lowest-index search for a free entry, an issuable entry and the entry a returning tag completes
    always_comb begin
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        w_fill_found  = 1'b0;
        w_fill_idx    = '0;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == ST_EMPTY) begin
                w_free_found = 1'b1;
                w_free_idx   = i[IDX_W-1:0];
            end
            if (r_state[i] == ST_WAIT_ISSUE) begin
                w_issue_found = 1'b1;
                w_issue_idx   = i[IDX_W-1:0];
            end
            if (r_state[i] == ST_WAIT_DATA && mem2proc_tag != 4'd0 &&
                r_mem_tag[i] == mem2proc_tag) begin
                w_fill_found = 1'b1;
                w_fill_idx   = i[IDX_W-1:0];
            end
        end
    end

    assign mshr_full     = ~w_free_found;
    assign miss_accept   = miss_en & w_free_found;
    assign w_resp_accept = w_issue_found & (mem2proc_response != 4'd0);
    assign w_fill_addr   = r_addr[w_fill_idx];

    // bus request comes only from registered entry state, so a fresh miss never reaches the bus in its own cycle
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 64'd0;
        if (w_issue_found) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {r_addr[w_issue_idx], 3'b000};
        end
    end

    // per-entry state machine; allocate, accept response and complete act on entries in distinct states
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_state[i]   <= ST_EMPTY;
                r_addr[i]    <= '0;
                r_ld_id[i]   <= '0;
                r_mem_tag[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                case (r_state[i])
                    ST_EMPTY: begin
                        if (miss_accept && w_free_idx == i[IDX_W-1:0]) begin
                            r_state[i] <= ST_WAIT_ISSUE;
                            r_addr[i]  <= miss_addr[63:3];
                            r_ld_id[i] <= miss_ld_id;
                        end
                    end
                    ST_WAIT_ISSUE: begin
                        if (w_resp_accept && w_issue_idx == i[IDX_W-1:0]) begin
                            r_state[i]   <= ST_WAIT_DATA;
                            r_mem_tag[i] <= mem2proc_response;
                        end
                    end
                    ST_WAIT_DATA: begin
                        if (w_fill_found && w_fill_idx == i[IDX_W-1:0]) begin
                            r_state[i] <= ST_EMPTY;
                        end
                    end
                    default: r_state[i] <= ST_EMPTY;
                endcase
            end
        end
    end

    // one-cycle fill pulse toward the cache array and load queue; all zero when idle
    always_ff @(posedge clock) begin
        if (reset || !w_fill_found) begin
            r_fill_valid <= 1'b0;
            r_fill_idx   <= '0;
            r_fill_tag   <= '0;
            r_fill_data  <= 64'd0;
            r_fill_ld_id <= '0;
        end else begin
            r_fill_valid <= 1'b1;
            r_fill_idx   <= w_fill_addr[`INDEX_BITS-1:0];
            r_fill_tag   <= w_fill_addr[60:`INDEX_BITS];
            r_fill_data  <= mem2proc_data;
            r_fill_ld_id <= r_ld_id[w_fill_idx];
        end
    end

    assign wr1_missed_load_en  = r_fill_valid;
    assign wr1_missed_load_idx = r_fill_idx;
    assign wr1_missed_load_tag = r_fill_tag;
    assign wr1_data_from_Mem   = r_fill_data;
    assign fill_valid          = r_fill_valid;
    assign fill_ld_id          = r_fill_ld_id;

`ifdef DCACHE_MSHR_STATS_EN
    logic [31:0] r_stat_miss_count;
    logic [31:0] r_stat_full_stall_count;

    // accepted-miss and full-stall counters, wrapping naturally at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_miss_count       <= 32'd0;
            r_stat_full_stall_count <= 32'd0;
        end else begin
            if (miss_accept) begin
                r_stat_miss_count <= r_stat_miss_count + 32'd1;
            end
            if (miss_en && mshr_full) begin
                r_stat_full_stall_count <= r_stat_full_stall_count + 32'd1;
            end
        end
    end

    assign stat_miss_count       = r_stat_miss_count;
    assign stat_full_stall_count = r_stat_full_stall_count;
`else
    // statistics counters are absent in this build
`endif

endmodule

// File: tb/tb_dcache_mshr.sv
// tb/tb_dcache_mshr.sv - directed self-checking bench for dcache_mshr
module tb_dcache_mshr;
    import dcache_mshr_pkg::*;

    logic        clock;
    logic        reset;
    logic        miss_en;
    logic [63:0] miss_addr;
    logic [4:0]  miss_ld_id;
    logic        miss_accept;
    logic        mshr_full;
    BUS_COMMAND  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic        wr1_missed_load_en;
    logic [4:0]  wr1_missed_load_idx;
    logic [55:0] wr1_missed_load_tag;
    logic [63:0] wr1_data_from_Mem;
    logic        fill_valid;
    logic [4:0]  fill_ld_id;
`ifdef DCACHE_MSHR_STATS_EN
    logic [31:0] stat_miss_count;
    logic [31:0] stat_full_stall_count;
`endif

    int checks;
    int failures;

    dcache_mshr #(.MSHR_DEPTH(4), .LD_ID_BITS(5)) dut (
        .clock               (clock),
        .reset               (reset),
        .miss_en             (miss_en),
        .miss_addr           (miss_addr),
        .miss_ld_id          (miss_ld_id),
        .miss_accept         (miss_accept),
        .mshr_full           (mshr_full),
        .proc2mem_command    (proc2mem_command),
        .proc2mem_addr       (proc2mem_addr),
        .mem2proc_response   (mem2proc_response),
        .mem2proc_tag        (mem2proc_tag),
        .mem2proc_data       (mem2proc_data),
        .wr1_missed_load_en  (wr1_missed_load_en),
        .wr1_missed_load_idx (wr1_missed_load_idx),
        .wr1_missed_load_tag (wr1_missed_load_tag),
        .wr1_data_from_Mem   (wr1_data_from_Mem),
        .fill_valid          (fill_valid),
        .fill_ld_id          (fill_ld_id)
`ifdef DCACHE_MSHR_STATS_EN
        ,
        .stat_miss_count       (stat_miss_count),
        .stat_full_stall_count (stat_full_stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        miss_en = 1'b0; miss_addr = 64'd0; miss_ld_id = 5'd0;
        mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (mshr_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", mshr_full); end
        checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL reset_cmd got=%0d exp=0", proc2mem_command); end
        checks++; if (proc2mem_addr !== 64'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", proc2mem_addr); end
        checks++; if (fill_valid !== 1'b0 || wr1_missed_load_en !== 1'b0) begin failures++; $display("FAIL reset_fill got=%b%b exp=00", fill_valid, wr1_missed_load_en); end
        checks++; if (wr1_data_from_Mem !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", wr1_data_from_Mem); end
    endtask

    task automatic test_single;
        miss_en = 1'b1; miss_addr = 64'h1008; miss_ld_id = 5'd3;
        #1;
        checks++; if (miss_accept !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", miss_accept); end
        checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL single_no_bypass got=%0d exp=0", proc2mem_command); end
        tick();
        miss_en = 1'b0;
        checks++; if (proc2mem_command !== BUS_LOAD) begin failures++; $display("FAIL single_issue_cmd got=%0d exp=1", proc2mem_command); end
        checks++; if (proc2mem_addr !== 64'h1008) begin failures++; $display("FAIL single_issue_addr got=%h exp=1008", proc2mem_addr); end
        mem2proc_response = 4'd5;
        tick();
        mem2proc_response = 4'd0;
        checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL single_wait_cmd got=%0d exp=0", proc2mem_command); end
        mem2proc_tag = 4'd5; mem2proc_data = 64'hCAFE;
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        checks++; if (fill_valid !== 1'b1 || wr1_missed_load_en !== 1'b1) begin failures++; $display("FAIL single_fill_valid got=%b%b exp=11", fill_valid, wr1_missed_load_en); end
        checks++; if (fill_ld_id !== 5'd3) begin failures++; $display("FAIL single_fill_id got=%0d exp=3", fill_ld_id); end
        checks++; if (wr1_data_from_Mem !== 64'hCAFE) begin failures++; $display("FAIL single_fill_data got=%h exp=cafe", wr1_data_from_Mem); end
        checks++; if (wr1_missed_load_idx !== 5'd1) begin failures++; $display("FAIL single_fill_idx got=%h exp=1", wr1_missed_load_idx); end
        checks++; if (wr1_missed_load_tag !== 56'h10) begin failures++; $display("FAIL single_fill_tag got=%h exp=10", wr1_missed_load_tag); end
        tick();
        checks++; if (fill_valid !== 1'b0 || wr1_data_from_Mem !== 64'd0 || fill_ld_id !== 5'd0) begin failures++; $display("FAIL single_fill_pulse got=%b/%h/%0d exp=0/0/0", fill_valid, wr1_data_from_Mem, fill_ld_id); end
    endtask

    task automatic test_reject;
        miss_en = 1'b1; miss_addr = 64'h2000; miss_ld_id = 5'd7;
        tick();
        miss_en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem2proc_response = (c == 3) ? 4'd2 : 4'd0;
            checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h2000) begin failures++; $display("FAIL reject_hold_%0d got=%0d/%h exp=1/2000", c, proc2mem_command, proc2mem_addr); end
            tick();
        end
        mem2proc_response = 4'd0;
        checks++; if (proc2mem_command !== BUS_NONE) begin failures++; $display("FAIL reject_wait_data got=%0d exp=0", proc2mem_command); end
        mem2proc_tag = 4'd2; mem2proc_data = 64'h1234;
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        checks++; if (fill_valid !== 1'b1 || fill_ld_id !== 5'd7 || wr1_missed_load_idx !== 5'd0 || wr1_missed_load_tag !== 56'h20) begin failures++; $display("FAIL reject_fill got=%b/%0d/%h/%h exp=1/7/0/20", fill_valid, fill_ld_id, wr1_missed_load_idx, wr1_missed_load_tag); end
        tick();
    endtask

    task automatic test_back_to_back;
        miss_en = 1'b1; miss_addr = 64'h4000; miss_ld_id = 5'd20;
        tick();
        miss_ld_id = 5'd21; mem2proc_response = 4'd7;
        #1;
        checks++; if (miss_accept !== 1'b1) begin failures++; $display("FAIL b2b_same_block_accept got=%b exp=1", miss_accept); end
        tick();
        checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h4000) begin failures++; $display("FAIL b2b_second_issue got=%0d/%h exp=1/4000", proc2mem_command, proc2mem_addr); end
        miss_addr = 64'h5000; miss_ld_id = 5'd22; mem2proc_response = 4'd8; mem2proc_tag = 4'd7; mem2proc_data = 64'hAA;
        #1;
        checks++; if (miss_accept !== 1'b1) begin failures++; $display("FAIL b2b_alloc_accept got=%b exp=1", miss_accept); end
        tick();
        miss_en = 1'b0;
        checks++; if (fill_valid !== 1'b1 || fill_ld_id !== 5'd20 || wr1_data_from_Mem !== 64'hAA) begin failures++; $display("FAIL b2b_fill0 got=%b/%0d/%h exp=1/20/aa", fill_valid, fill_ld_id, wr1_data_from_Mem); end
        checks++; if (proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h5000) begin failures++; $display("FAIL b2b_third_issue got=%0d/%h exp=1/5000", proc2mem_command, proc2mem_addr); end
        mem2proc_response = 4'd9; mem2proc_tag = 4'd8; mem2proc_data = 64'hBB;
        tick();
        checks++; if (fill_valid !== 1'b1 || fill_ld_id !== 5'd21 || wr1_missed_load_tag !== 56'h40 || wr1_missed_load_idx !== 5'd0) begin failures++; $display("FAIL b2b_fill1 got=%b/%0d/%h/%h exp=1/21/40/0", fill_valid, fill_ld_id, wr1_missed_load_tag, wr1_missed_load_idx); end
        mem2proc_response = 4'd0; mem2proc_tag = 4'd9; mem2proc_data = 64'hCC;
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        checks++; if (fill_valid !== 1'b1 || fill_ld_id !== 5'd22 || wr1_missed_load_tag !== 56'h50) begin failures++; $display("FAIL b2b_fill2 got=%b/%0d/%h exp=1/22/50", fill_valid, fill_ld_id, wr1_missed_load_tag); end
        tick();
    endtask

    task automatic test_full;
        logic [3:0] ret_tags [4];
        logic [4:0] ret_ids  [4];
        ret_tags = '{4'd1, 4'd2, 4'd4, 4'd6};
        ret_ids  = '{5'd1, 5'd2, 5'd4, 5'd5};
        for (int i = 0; i < 4; i++) begin
            miss_en = 1'b1; miss_addr = 64'h100 * (i + 1); miss_ld_id = 5'(i + 1);
            #1;
            checks++; if (miss_accept !== 1'b1) begin failures++; $display("FAIL full_alloc_%0d got=%b exp=1", i, miss_accept); end
            tick();
        end
        miss_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem2proc_response = 4'(i + 1);
            tick();
        end
        mem2proc_response = 4'd0;
        miss_en = 1'b1; miss_addr = 64'h500; miss_ld_id = 5'd5;
        #1;
        checks++; if (mshr_full !== 1'b1 || miss_accept !== 1'b0) begin failures++; $display("FAIL full_reject got=%b/%b exp=1/0", mshr_full, miss_accept); end
        mem2proc_tag = 4'd3; mem2proc_data = 64'h33;
        #1;
        checks++; if (miss_accept !== 1'b0) begin failures++; $display("FAIL full_no_same_cycle got=%b exp=0", miss_accept); end
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        checks++; if (fill_valid !== 1'b1 || fill_ld_id !== 5'd3) begin failures++; $display("FAIL full_free_fill got=%b/%0d exp=1/3", fill_valid, fill_ld_id); end
        checks++; if (mshr_full !== 1'b0 || miss_accept !== 1'b1) begin failures++; $display("FAIL full_next_accept got=%b/%b exp=0/1", mshr_full, miss_accept); end
        tick();
        miss_en = 1'b0;
        checks++; if (mshr_full !== 1'b1 || proc2mem_command !== BUS_LOAD || proc2mem_addr !== 64'h500) begin failures++; $display("FAIL full_reuse got=%b/%0d/%h exp=1/1/500", mshr_full, proc2mem_command, proc2mem_addr); end
        mem2proc_response = 4'd6;
        tick();
        mem2proc_response = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mem2proc_tag = ret_tags[i];
            tick();
            checks++; if (fill_valid !== 1'b1 || fill_ld_id !== ret_ids[i]) begin failures++; $display("FAIL full_drain_%0d got=%b/%0d exp=1/%0d", i, fill_valid, fill_ld_id, ret_ids[i]); end
        end
        mem2proc_tag = 4'd0;
        tick();
        checks++; if (mshr_full !== 1'b0 || fill_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b/%b exp=0/0", mshr_full, fill_valid); end
    endtask

    task automatic test_out_of_order;
        logic [63:0] addrs [3];
        logic [3:0]  order [3];
        logic [4:0]  exp_id  [3];
        logic [4:0]  exp_idx [3];
        logic [55:0] exp_tag [3];
        logic [63:0] datas [3];
        addrs   = '{64'hA08, 64'hB10, 64'hC18};
        order   = '{4'd3, 4'd1, 4'd2};
        exp_id  = '{5'd12, 5'd10, 5'd11};
        exp_idx = '{5'd3, 5'd1, 5'd2};
        exp_tag = '{56'hC, 56'hA, 56'hB};
        datas   = '{64'h3333, 64'h1111, 64'h2222};
        for (int i = 0; i < 3; i++) begin
            miss_en = 1'b1; miss_addr = addrs[i]; miss_ld_id = 5'(10 + i);
            tick();
        end
        miss_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem2proc_response = 4'(i + 1);
            tick();
        end
        mem2proc_response = 4'd0;
        for (int i = 0; i < 3; i++) begin
            mem2proc_tag = order[i]; mem2proc_data = datas[i];
            tick();
            checks++; if (fill_valid !== 1'b1 || fill_ld_id !== exp_id[i] || wr1_missed_load_idx !== exp_idx[i] || wr1_missed_load_tag !== exp_tag[i] || wr1_data_from_Mem !== datas[i]) begin
                failures++; $display("FAIL ooo_fill_%0d got=%b/%0d/%h/%h/%h exp=1/%0d/%h/%h/%h", i, fill_valid, fill_ld_id, wr1_missed_load_idx, wr1_missed_load_tag, wr1_data_from_Mem, exp_id[i], exp_idx[i], exp_tag[i], datas[i]);
            end
        end
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        tick();
    endtask

    task automatic test_reset_midflight;
        for (int i = 0; i < 2; i++) begin
            miss_en = 1'b1; miss_addr = 64'h7000 + 64'(8 * i); miss_ld_id = 5'(1 + i);
            tick();
        end
        miss_en = 1'b0;
        mem2proc_response = 4'd11; tick();
        mem2proc_response = 4'd12; tick();
        mem2proc_response = 4'd0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem2proc_tag = 4'd11; mem2proc_data = 64'hDEAD;
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        checks++; if (fill_valid !== 1'b0 || wr1_missed_load_en !== 1'b0) begin failures++; $display("FAIL midreset_no_fill got=%b/%b exp=0/0", fill_valid, wr1_missed_load_en); end
        checks++; if (mshr_full !== 1'b0 || proc2mem_command !== BUS_NONE || proc2mem_addr !== 64'd0) begin failures++; $display("FAIL midreset_idle got=%b/%0d/%h exp=0/0/0", mshr_full, proc2mem_command, proc2mem_addr); end
    endtask

`ifdef DCACHE_MSHR_STATS_EN
    task automatic test_stats;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (stat_miss_count !== 32'd0 || stat_full_stall_count !== 32'd0) begin failures++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", stat_miss_count, stat_full_stall_count); end
        for (int i = 0; i < 6; i++) begin
            miss_en = 1'b1; miss_addr = 64'h9000 + 64'(64 * i); miss_ld_id = 5'(i);
            tick();
        end
        miss_en = 1'b0;
        checks++; if (stat_miss_count !== 32'd4 || stat_full_stall_count !== 32'd2) begin failures++; $display("FAIL stats_counts got=%0d/%0d exp=4/2", stat_miss_count, stat_full_stall_count); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single();
        test_reject();
        test_back_to_back();
        test_full();
        test_out_of_order();
        test_reset_midflight();
`ifdef DCACHE_MSHR_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
DCACHE_MSHR -- requirements
Module: dcache_mshr

Interface
REQ-001 SHALL have parameter MSHR_DEPTH, default 4, number of outstanding miss entries (2..8).
REQ-002 SHALL have parameter LD_ID_BITS, default 5, width of the load-queue identifier carried with each miss.
REQ-003 SHALL have ports `clock` (in, 1, the single clock) and `reset` (in, 1, synchronous, active-high).
REQ-004 SHALL have ports `miss_en` (in, 1, new load miss this cycle), `miss_addr` (in, 64, byte address) and `miss_ld_id` (in, LD_ID_BITS, requesting load).
REQ-005 SHALL have output `miss_accept` (1, miss captured this cycle) and output `mshr_full` (1, no free entry).
REQ-006 SHALL have output `proc2mem_command` (BUS_COMMAND, BUS_LOAD or BUS_NONE) and output `proc2mem_addr` (64, 8-byte-aligned block address).
REQ-007 SHALL have inputs `mem2proc_response` (4, 0 = request rejected, else transaction tag), `mem2proc_tag` (4, 0 = no data, else tag of returning data) and `mem2proc_data` (64).
REQ-008 SHALL have outputs `wr1_missed_load_en` (1), `wr1_missed_load_idx` (`INDEX_BITS), `wr1_missed_load_tag` (`TAG_BITS) and `wr1_data_from_Mem` (64), all driving the cache fill port.
REQ-009 SHALL have outputs `fill_valid` (1) and `fill_ld_id` (LD_ID_BITS), the load wakeup to the LSQ; data is `wr1_data_from_Mem`.

Function
REQ-010 Each entry SHALL be in one of three states: EMPTY, WAIT_ISSUE or WAIT_DATA.
REQ-011 `mshr_full` SHALL equal 1 when no entry is EMPTY at the start of the cycle, and `miss_accept` SHALL equal miss_en AND NOT mshr_full.
REQ-012 On accept, the lowest-index EMPTY entry SHALL capture addr[63:3], ld_id and EMPTY->WAIT_ISSUE at the clock edge.
REQ-013 A miss arriving while full SHALL be dropped; the requester holds it.
REQ-014 An entry freed in cycle N SHALL NOT be allocatable before cycle N+1.
REQ-015 `proc2mem_command` SHALL be BUS_LOAD with `proc2mem_addr`={entry addr,3'b0} of the lowest-index WAIT_ISSUE entry, else BUS_NONE with addr 0; both outputs are combinational from registered state.
REQ-016 Issue is earliest in the cycle after allocation; allocation SHALL never bypass to the bus.
REQ-017 If BUS_LOAD and mem2proc_response!=0, the issued entry SHALL store the response as mem_tag and go WAIT_DATA.
REQ-018 If mem2proc_response==0, the entry SHALL stay WAIT_ISSUE and re-issue the same address next cycle.
REQ-019 If mem2proc_tag!=0 and matches a WAIT_DATA entry's mem_tag, that entry SHALL go EMPTY at the edge.
REQ-020 In that match case, the outputs SHALL pulse for exactly one cycle after the edge:
- `wr1_missed_load_en`=1 and `fill_valid`=1
- `wr1_missed_load_idx`=addr[3+`INDEX_BITS-1:3]
- `wr1_missed_load_tag`=addr[63:3+`INDEX_BITS]
- `wr1_data_from_Mem`=registered mem2proc_data
- `fill_ld_id`=stored id
REQ-021 When no fill is pending, fill outputs SHALL be 0 (data 0).
REQ-022 Unmatched nonzero mem2proc_tag SHALL be ignored; memory guarantees unique outstanding tags.
REQ-023 Issue, response capture, data completion and allocation in one cycle SHALL all take effect independently on distinct entries.
REQ-024 Misses to the same block SHALL each occupy their own entry and issue separately.

Reset
REQ-025 While `reset` is high at an edge, all entries SHALL become EMPTY and fill outputs 0; therefore after reset mshr_full=0, proc2mem_command=BUS_NONE, proc2mem_addr=0.
REQ-026 Reset mid-operation SHALL discard all outstanding misses; data returning afterwards SHALL be ignored per REQ-022.

Configuration
REQ-027 With `DCACHE_MSHR_STATS_EN` defined, the block SHALL expose outputs `stat_miss_count` (32, +1 per accepted miss) and `stat_full_stall_count` (32, +1 per cycle with miss_en AND mshr_full); both reset to 0 and wrap at 2^32.
REQ-028 Without `DCACHE_MSHR_STATS_EN`, these ports and counters SHALL not exist, and behaviour is otherwise identical.

Verification
REQ-029 Single miss: reset; miss 0x1008, id 3; response 5 -> BUS_LOAD addr 0x1008 next cycle; tag 5 with data 0xCAFE -> one cycle of fill_valid with id 3, data 0xCAFE and idx/tag from 0x1008; entry freed.
REQ-030 Rejection: response 0 for 3 cycles, then 2 -> BUS_LOAD 0x2000 held for 4 cycles, WAIT_DATA after the 4th.
REQ-031 Full: 4 misses with no data return -> mshr_full=1; 5th miss_accept=0; tag return frees an entry -> 5th accepted the following cycle, not the same cycle.
REQ-032 Out-of-order: entries get tags 1,2,3; data returns 3,1,2 -> fills in order with matching ld_ids and addresses.
REQ-033 Reset mid-flight: 2 entries WAIT_DATA, reset, then mem2proc_tag of an old tag -> no fill, mshr_full=0, BUS_NONE.
REQ-034 Stats (macro on): 6 misses against depth 4 with no returns -> stat_miss_count=4, stat_full_stall_count=2.
